// File: rtl/axi_join_n_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_join_n_if
// Brief    : Bundle of the N input AXI-Stream channels and the joined output stream.
// Revision : 1.0
// ============================================================================
interface axi_join_n_if #(
  parameter int NUM_CH    = 2,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16
);
  logic [NUM_CH*IN_WIDTH-1:0]  i_tdata;
  logic [NUM_CH-1:0]           i_tlast;
  logic [NUM_CH-1:0]           i_tvalid;
  logic [NUM_CH-1:0]           i_tready;
  logic [NUM_CH*OUT_WIDTH-1:0] o_tdata;
  logic                        o_tlast;
  logic                        o_tvalid;
  logic                        o_tready;

  modport slave (
    input  i_tdata, i_tlast, i_tvalid, o_tready,
    output i_tready, o_tdata, o_tlast, o_tvalid
  );

  modport master (
    output i_tdata, i_tlast, i_tvalid, o_tready,
    input  i_tready, o_tdata, o_tlast, o_tvalid
  );
endinterface
`default_nettype wire

// File: rtl/axi_join_n.sv
`default_nettype none
// ============================================================================
// Module   : axi_join_n
// Brief    : Joins NUM_CH AXI-Stream channels into one beat, MSB slices packed.
// Revision : 1.0
// ============================================================================
module axi_join_n #(
  parameter int NUM_CH    = 2,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16,
  parameter int STRICT    = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  axi_join_n_if.slave        bus,
  output logic [15:0]        err_count,
  output logic               err_stb
);

  localparam int C_OW = NUM_CH * OUT_WIDTH;

  typedef enum logic [0:0] {
    ST_JOIN   = 1'b0,
    ST_RESYNC = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_CH-1:0]   r_done_mask;
  logic [NUM_CH-1:0]   w_done_mask_nxt;
  logic [NUM_CH-1:0]   w_mask_upd;
  logic [NUM_CH-1:0]   w_ready;
  logic                r_ready_en;

  logic [C_OW-1:0]     w_join_data;
  logic                w_join_last;
  logic                w_mixed;
  logic                w_all_valid;
  logic                w_join_fire;
  logic                w_pop;
  logic                w_unused_lsbs;

  logic                r_head_v;
  logic [C_OW-1:0]     r_head_data;
  logic                r_head_last;
  logic                r_tail_v;
  logic [C_OW-1:0]     r_tail_data;
  logic                r_tail_last;

  logic [15:0]         r_err_count;
  logic                r_err_stb;

  // Channel 0 lands in the most significant slice of the output word.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
    assign w_join_data[(NUM_CH-1-k)*OUT_WIDTH +: OUT_WIDTH] =
      bus.i_tdata[k*IN_WIDTH + (IN_WIDTH-OUT_WIDTH) +: OUT_WIDTH];
  end

  assign w_unused_lsbs = ^bus.i_tdata;
  assign w_all_valid   = &bus.i_tvalid;
  assign w_join_last   = |bus.i_tlast;
  assign w_mixed       = (|bus.i_tlast) && !(&bus.i_tlast);
  assign w_join_fire   = (r_state == ST_JOIN) && r_ready_en && !clear &&
                         w_all_valid && !r_tail_v;
  assign w_pop         = r_head_v && bus.o_tready;

  always_comb begin
    w_state_nxt     = r_state;
    w_done_mask_nxt = r_done_mask;
    w_ready         = '0;
    w_mask_upd      = r_done_mask;
    if (r_ready_en && !clear) begin
      case (r_state)
        ST_JOIN: begin
          w_ready = {NUM_CH{w_join_fire}};
          if (w_join_fire && w_mixed && (STRICT != 0)) begin
            w_state_nxt     = ST_RESYNC;
            w_done_mask_nxt = bus.i_tlast;
          end
        end
        ST_RESYNC: begin
          // Unfinished channels are drained until their own tlast is seen.
          w_ready    = ~r_done_mask;
          w_mask_upd = r_done_mask | (~r_done_mask & bus.i_tvalid & bus.i_tlast);
          if (&w_mask_upd) begin
            w_state_nxt     = ST_JOIN;
            w_done_mask_nxt = '0;
          end else begin
            w_done_mask_nxt = w_mask_upd;
          end
        end
        default: begin
          w_state_nxt     = ST_JOIN;
          w_done_mask_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_JOIN;
      r_done_mask <= '0;
      r_ready_en  <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (clear) begin
        r_state     <= ST_JOIN;
        r_done_mask <= '0;
      end else begin
        r_state     <= w_state_nxt;
        r_done_mask <= w_done_mask_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_count <= 16'd0;
      r_err_stb   <= 1'b0;
    end else if (clear) begin
      r_err_count <= 16'd0;
      r_err_stb   <= 1'b0;
    end else begin
      r_err_stb <= w_join_fire && w_mixed;
      if (w_join_fire && w_mixed && (r_err_count != 16'hFFFF)) begin
        r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  // Two-entry buffer: head feeds the output directly, tail holds the overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head_v    <= 1'b0;
      r_head_data <= '0;
      r_head_last <= 1'b0;
      r_tail_v    <= 1'b0;
      r_tail_data <= '0;
      r_tail_last <= 1'b0;
    end else if (clear) begin
      r_head_v <= 1'b0;
      r_tail_v <= 1'b0;
    end else begin
      case ({w_join_fire, w_pop})
        2'b11: begin
          r_head_data <= w_join_data;
          r_head_last <= w_join_last;
        end
        2'b01: begin
          r_head_v    <= r_tail_v;
          r_head_data <= r_tail_data;
          r_head_last <= r_tail_last;
          r_tail_v    <= 1'b0;
        end
        2'b10: begin
          if (!r_head_v) begin
            r_head_v    <= 1'b1;
            r_head_data <= w_join_data;
            r_head_last <= w_join_last;
          end else begin
            r_tail_v    <= 1'b1;
            r_tail_data <= w_join_data;
            r_tail_last <= w_join_last;
          end
        end
        default: begin
          r_head_v <= r_head_v;
        end
      endcase
    end
  end

  assign bus.i_tready = w_ready;
  assign bus.o_tvalid = r_head_v;
  assign bus.o_tdata  = r_head_data;
  assign bus.o_tlast  = r_head_last;
  assign err_count    = r_err_count;
  assign err_stb      = r_err_stb;

endmodule
`default_nettype wire

// File: tb/tb_axi_join_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_join_n
// Brief    : Self-checking bench: directed cases plus random streams vs a join model.
// Revision : 1.0
// ============================================================================
module tb_axi_join_n;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic [31:0] drv_data [4];
  logic [3:0]  drv_last;
  logic [3:0]  drv_valid;
  logic        out_ready;
  int          sel;

  int n_checks = 0;
  int n_errors = 0;

  beat_t       src [4][$];
  logic [64:0] exp_q [$];
  int          exp_err;

  always #5 clk = ~clk;

  axi_join_n_if #(.NUM_CH(2), .IN_WIDTH(32), .OUT_WIDTH(16)) bus_a ();
  axi_join_n_if #(.NUM_CH(4), .IN_WIDTH(32), .OUT_WIDTH(16)) bus_b ();

  logic [15:0] errc_a, errc_b;
  logic        stb_a, stb_b;

  axi_join_n #(.NUM_CH(2), .IN_WIDTH(32), .OUT_WIDTH(16), .STRICT(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus_a),
    .err_count(errc_a), .err_stb(stb_a)
  );

  axi_join_n #(.NUM_CH(4), .IN_WIDTH(32), .OUT_WIDTH(16), .STRICT(0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus_b),
    .err_count(errc_b), .err_stb(stb_b)
  );

  assign bus_a.i_tdata  = {drv_data[1], drv_data[0]};
  assign bus_a.i_tlast  = drv_last[1:0];
  assign bus_a.i_tvalid = (sel == 0) ? drv_valid[1:0] : 2'b00;
  assign bus_a.o_tready = out_ready;
  assign bus_b.i_tdata  = {drv_data[3], drv_data[2], drv_data[1], drv_data[0]};
  assign bus_b.i_tlast  = drv_last;
  assign bus_b.i_tvalid = (sel == 1) ? drv_valid : 4'b0000;
  assign bus_b.o_tready = out_ready;

  // Unified view of whichever unit is selected.
  logic [3:0]  rdy;
  logic        ov, ol, es;
  logic [63:0] od;
  logic [15:0] ec;

  always_comb begin
    rdy = '0; ov = 1'b0; ol = 1'b0; od = '0; ec = '0; es = 1'b0;
    if (sel == 0) begin
      rdy[1:0]  = bus_a.i_tready;
      ov        = bus_a.o_tvalid;
      ol        = bus_a.o_tlast;
      od[31:0]  = bus_a.o_tdata;
      ec        = errc_a;
      es        = stb_a;
    end else begin
      rdy = bus_b.i_tready;
      ov  = bus_b.o_tvalid;
      ol  = bus_b.o_tlast;
      od  = bus_b.o_tdata;
      ec  = errc_b;
      es  = stb_b;
    end
  end

  task automatic check_value(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int s);
    sel = s; drv_valid = '0; drv_last = '0; out_ready = 1'b0; clear = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic push_pkt(input int c, input int len, input logic [15:0] base);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = {base + 16'(i), 16'h5A5A};
      b.l = (i == len - 1);
      src[c].push_back(b);
    end
  endtask

  task automatic gen_random(input int nch, input int npkt);
    beat_t b;
    int base, len;
    for (int c = 0; c < 4; c++) src[c].delete();
    for (int p = 0; p < npkt; p++) begin
      base = $urandom_range(1, 4);
      for (int c = 0; c < nch; c++) begin
        len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : base;
        for (int i = 0; i < len; i++) begin
          b.d = $urandom();
          b.l = (i == len - 1);
          src[c].push_back(b);
        end
      end
    end
  endtask

  // Packet-level reference: zip heads; on mixed tlast, strict mode skips
  // the unfinished channels to the end of their current packet.
  task automatic build_model(input int nch, input bit strict);
    beat_t       q [4][$];
    beat_t       b;
    logic [3:0]  lv;
    logic [63:0] data;
    bit          stop, any, all, done;
    exp_q.delete();
    exp_err = 0;
    for (int c = 0; c < 4; c++) q[c] = src[c];
    stop = 1'b0;
    while (!stop) begin
      for (int c = 0; c < nch; c++) if (q[c].size() == 0) stop = 1'b1;
      if (!stop) begin
        data = '0; lv = '0; any = 1'b0; all = 1'b1;
        for (int c = 0; c < nch; c++) begin
          b = q[c].pop_front();
          data[(nch-1-c)*16 +: 16] = b.d[31:16];
          lv[c] = b.l;
          any |= b.l;
          all &= b.l;
        end
        exp_q.push_back({any, data});
        if (any && !all) begin
          exp_err++;
          if (strict) begin
            for (int c = 0; c < nch; c++) begin
              if (!lv[c]) begin
                done = 1'b0;
                while (!done && q[c].size() > 0) begin
                  b = q[c].pop_front();
                  done = b.l;
                end
                if (!done) stop = 1'b1;
              end
            end
          end
        end
      end
    end
  endtask

  task automatic run_stream(input int nch, input bit strict, input string tag);
    logic [64:0] got_q [$];
    logic [3:0]  hsv;
    beat_t       b;
    int          stb_cnt, cyc, tail;
    build_model(nch, strict);
    stb_cnt = 0; cyc = 0; tail = 0;
    drv_valid = '0;
    while (tail < 20 && cyc < 4000) begin
      for (int c = 0; c < nch; c++) begin
        if (!drv_valid[c] && src[c].size() > 0 && $urandom_range(0, 3) != 0) begin
          drv_valid[c] = 1'b1;
          drv_data[c]  = src[c][0].d;
          drv_last[c]  = src[c][0].l;
        end
      end
      out_ready = (tail > 0) || ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (ov && out_ready) got_q.push_back({ol, od});
      if (es) stb_cnt++;
      hsv = drv_valid & rdy;
      @(posedge clk); #1;
      for (int c = 0; c < nch; c++) begin
        if (hsv[c]) begin
          b = src[c].pop_front();
          drv_valid[c] = 1'b0;
        end
      end
      cyc++;
      if (got_q.size() >= exp_q.size()) tail++;
    end
    drv_valid = '0;
    check_value({tag, " timeout"}, 80'(cyc >= 4000), 80'd0);
    check_value({tag, " beat_count"}, 80'(got_q.size()), 80'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check_value($sformatf("%s beat%0d", tag, i), 80'(got_q[i]), 80'(exp_q[i]));
    end
    check_value({tag, " err_count"}, 80'(ec), 80'(exp_err));
    check_value({tag, " err_stb_pulses"}, 80'(stb_cnt), 80'(exp_err));
  endtask

  initial begin
    int n_in, n_acc;
    bit hs;

    // Reset values, then the reference two-channel join.
    sel = 0; clear = 1'b0; out_ready = 1'b1; reset_n = 1'b0;
    drv_data[0] = 32'hAAAA1111; drv_data[1] = 32'hBBBB2222;
    drv_data[2] = '0; drv_data[3] = '0;
    drv_last = 4'b0011; drv_valid = 4'b0011;
    repeat (2) @(negedge clk);
    check_value("rst o_tvalid", 80'(ov), 80'd0);
    check_value("rst o_tlast", 80'(ol), 80'd0);
    check_value("rst o_tdata", 80'(od), 80'd0);
    check_value("rst i_tready", 80'(rdy), 80'd0);
    check_value("rst err_count", 80'(ec), 80'd0);
    check_value("rst err_stb", 80'(es), 80'd0);
    #2 reset_n = 1'b1;
    #1 check_value("ready before first edge", 80'(rdy), 80'd0);
    @(negedge clk);
    check_value("basic ready", 80'(rdy), 80'h3);
    @(posedge clk); #1 drv_valid = '0;
    @(negedge clk);
    check_value("basic o_tvalid", 80'(ov), 80'd1);
    check_value("basic o_tdata", 80'(od), 80'h0000_0000_AAAA_BBBB);
    check_value("basic o_tlast", 80'(ol), 80'd1);
    check_value("basic err_count", 80'(ec), 80'd0);

    // Staggered valids on four channels.
    do_reset(1); out_ready = 1'b1; drv_last = 4'b1111;
    for (int k = 0; k < 4; k++) drv_data[k] = {16'h1000 + 16'(k), 16'hFFFF};
    for (int k = 0; k < 4; k++) begin
      drv_valid[k] = 1'b1;
      @(negedge clk);
      check_value($sformatf("stagger ready c%0d", k), 80'(rdy), (k == 3) ? 80'hF : 80'h0);
      check_value($sformatf("stagger o_tvalid c%0d", k), 80'(ov), 80'd0);
      @(posedge clk); #1;
    end
    drv_valid = '0;
    @(negedge clk);
    check_value("stagger out", 80'({ov, ol, od}), {14'd0, 1'b1, 1'b1, 64'h1000_1001_1002_1003});

    // Backpressure: exactly two beats buffered, then ordered back-to-back drain.
    do_reset(0); out_ready = 1'b0; drv_last = '0; drv_valid = 4'b0011;
    n_in = 0; n_acc = 0;
    drv_data[0] = {16'(n_in), 16'h0}; drv_data[1] = {~16'(n_in), 16'h0};
    repeat (10) begin
      @(negedge clk);
      hs = (rdy[1:0] == 2'b11);
      @(posedge clk); #1;
      if (hs) begin
        n_acc++; n_in++;
        drv_data[0] = {16'(n_in), 16'h0}; drv_data[1] = {~16'(n_in), 16'h0};
      end
    end
    check_value("bp accepted", 80'(n_acc), 80'd2);
    @(negedge clk);
    check_value("bp ready low", 80'(rdy), 80'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_value($sformatf("drain %0d", k), 80'({ov, od[31:0]}), 80'({1'b1, 16'(k), ~16'(k)}));
      hs = (rdy[1:0] == 2'b11);
      @(posedge clk); #1;
      if (hs) begin
        n_in++;
        drv_data[0] = {16'(n_in), 16'h0}; drv_data[1] = {~16'(n_in), 16'h0};
      end
    end
    drv_valid = '0;

    // ch0 ends at beat 3, ch1 at beat 5: strict resync, then relaxed zip.
    for (int c = 0; c < 4; c++) src[c].delete();
    push_pkt(0, 3, 16'h0100); push_pkt(0, 2, 16'h0200);
    push_pkt(1, 5, 16'h1100); push_pkt(1, 2, 16'h1200);
    do_reset(0);
    run_stream(2, 1'b1, "strict_pkt");
    for (int c = 0; c < 4; c++) src[c].delete();
    push_pkt(0, 3, 16'h0100); push_pkt(0, 2, 16'h0200);
    push_pkt(1, 5, 16'h1100); push_pkt(1, 2, 16'h1200);
    push_pkt(2, 3, 16'h2100); push_pkt(2, 2, 16'h2200);
    push_pkt(3, 5, 16'h3100); push_pkt(3, 2, 16'h3200);
    do_reset(1);
    run_stream(4, 1'b0, "relaxed_pkt");

    for (int r = 0; r < 2; r++) begin
      gen_random(2, 25); do_reset(0);
      run_stream(2, 1'b1, $sformatf("rand_a%0d", r));
      gen_random(4, 25); do_reset(1);
      run_stream(4, 1'b0, $sformatf("rand_b%0d", r));
    end

    // Asynchronous reset while resyncing.
    do_reset(0); out_ready = 1'b1;
    drv_data[0] = 32'h12340000; drv_data[1] = 32'h56780000;
    drv_last = 4'b0001; drv_valid = 4'b0011;
    @(negedge clk);
    check_value("mixed accept ready", 80'(rdy), 80'h3);
    @(posedge clk); #1 drv_last = 4'b0000;
    @(negedge clk);
    check_value("resync ready", 80'(rdy), 80'h2);
    #2 reset_n = 1'b0;
    #1;
    check_value("async rst o_tvalid", 80'(ov), 80'd0);
    check_value("async rst i_tready", 80'(rdy), 80'd0);
    check_value("async rst err_count", 80'(ec), 80'd0);
    check_value("async rst err_stb", 80'(es), 80'd0);
    @(posedge clk); #1 reset_n = 1'b1; drv_last = 4'b0011;
    @(posedge clk); #1;
    @(negedge clk);
    check_value("join after reset", 80'(rdy), 80'h3);
    @(posedge clk); #1 drv_valid = '0;
    @(negedge clk);
    check_value("out after reset", 80'({ov, ol, od}), {14'd0, 1'b1, 1'b1, 64'h1234_5678});

    // Synchronous clear while resyncing with a buffered beat.
    do_reset(0); out_ready = 1'b0;
    drv_last = 4'b0001; drv_valid = 4'b0011;
    @(posedge clk); #1 clear = 1'b1; drv_last = 4'b0000;
    @(negedge clk);
    check_value("clear ready", 80'(rdy), 80'd0);
    check_value("err before clear", 80'(ec), 80'd1);
    check_value("stb before clear", 80'(es), 80'd1);
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    check_value("clear o_tvalid", 80'(ov), 80'd0);
    check_value("clear err_count", 80'(ec), 80'd0);
    check_value("clear err_stb", 80'(es), 80'd0);
    check_value("join after clear", 80'(rdy), 80'h3);
    @(posedge clk); #1 drv_valid = '0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
